ebr_fifo_core: RTL and testbench
================================

Name: ebr_fifo_core

Overview:
- Parametrised synchronous FIFO modelled on the EBR FIFO16K mode.
- Generalises the single-mode EBR_CORE instance to configurable width, depth, flag thresholds and output-register mode.
- Serves as the behavioural golden model for FIFO-mode fuzzing/simulation, and as a synthesisable block-RAM FIFO in user designs.
- One clock domain; storage is a simple dual-port RAM.

Parameters:
- DATA_WIDTH, 18, data bits per word (1..36).
- DEPTH, 1024, words of storage; power of two, 16..16384.
- AFULL_THRESH, DEPTH-4, AFULL asserts when count >= this value.
- AEMPTY_THRESH, 4, AEMPTY asserts when count <= this value.
- REGMODE, 0, 0 = read data 1 cycle after RE; 1 = extra output register, 2 cycles.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- WE  in  1  write request.
- DI  in  DATA_WIDTH  write data.
- RE  in  1  read request.
- DO  out  DATA_WIDTH  read data.
- DO_VALID  out  1  DO holds a newly read word this cycle.
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- AFULL  out  1  count >= AFULL_THRESH.
- AEMPTY  out  1  count <= AEMPTY_THRESH.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- OVF  out  1  sticky: write attempted while FULL.
- UNF  out  1  sticky: read attempted while EMPTY.

Behaviour:
- One clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - wr/rd pointers 0, COUNT 0.
  - EMPTY 1, AEMPTY 1, FULL 0, AFULL 0 (for AFULL_THRESH > 0).
  - DO all-zero, DO_VALID 0, OVF 0, UNF 0.
- Reset mid-operation:
  - Stored RAM contents are not cleared but become unreachable.
  - In-flight reads are cancelled: DO_VALID is 0 in the cycle after reset, including the REGMODE=1 stage.
- Write acceptance:
  - wr_ok = WE & ~FULL, using the registered FULL.
  - A simultaneous RE does not free space in the same cycle: write while FULL is always rejected.
- Read acceptance:
  - rd_ok = RE & ~EMPTY, using the registered EMPTY.
  - A simultaneous WE does not make data readable in the same cycle; there is no fall-through.
- Pointers:
  - $clog2(DEPTH) bits each; each increments on its accept and wraps DEPTH-1 -> 0.
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both accept or neither does.
- Flags: all registered, computed from next COUNT, so they are valid the cycle after the causing edge.
- Read latency:
  - REGMODE=0: word at rd_ptr appears on DO the cycle after rd_ok; DO_VALID pulses with it.
  - REGMODE=1: one further register stage; DO and DO_VALID follow 2 cycles after rd_ok.
  - DO holds its last value when no read is in flight.
- Read-during-write: the same address cannot collide, because the empty/full rules forbid it. The RAM read port is read-first.
- Error flags:
  - A rejected WE sets OVF; a rejected RE sets UNF.
  - Both are sticky until RST.
  - Rejected operations change no other state.
- Throughput: back-to-back accepts every cycle are allowed on both ports.

Optional Feature:
- Macro: EBR_FIFO_PARITY_EN.
- Defined:
  - RAM width becomes DATA_WIDTH + ceil(DATA_WIDTH/9): one even-parity bit per 9-bit byte lane, generated on write.
  - Extra output PERR (1 bit) is checked on read, aligned with DO_VALID, and asserts when any lane mismatches.
  - PERR resets to 0 and is not sticky.
- Undefined:
  - No parity storage and no PERR port.
  - RAM width equals DATA_WIDTH.

Decomposition:
- Package ebr_fifo_pkg:
  - regmode_e enum (REG_NONE=0, REG_OUT=1).
  - Function par_lanes(width) = (width+8)/9.
  - Function cnt_w(depth) = $clog2(depth)+1.
  - Limits MAX_WIDTH=36, MAX_DEPTH=16384.
- Sub-module ebr_sdp_ram:
  - Contents: DEPTH x RAM_W array, one write port and one synchronous read port on CLK, read-first.
  - Inferable as EBR.
- ebr_fifo_core holds the pointers, count, flags, output register and parity.

Test Plan (DEPTH=16, DATA_WIDTH=18, AFULL_THRESH=12, AEMPTY_THRESH=2):
- Fill/drain, REGMODE=0:
  - Write 0x00001..0x00010 on consecutive cycles -> FULL=1 the cycle after the 16th write, COUNT=16, AFULL=1 from COUNT 12.
  - Read 16 -> DO sequence 0x00001..0x00010, each 1 cycle after RE, then EMPTY=1.
- REGMODE=1, same stimulus -> identical DO sequence, but each DO_VALID arrives 2 cycles after its RE.
- Full boundary: with FIFO full, assert WE and RE together with DI=0x3FFFF -> read accepted, write rejected, OVF=1, COUNT=15, 0x3FFFF is never read.
- Empty boundary: with FIFO empty, assert WE=1 (DI=0x00ABC) and RE=1 together -> UNF=1, COUNT=1; the next RE returns 0x00ABC.
- Wrap and reset:
  - Run 40 interleaved write/read pairs -> pointers wrap and data order is preserved.
  - Assert RST while a REGMODE=1 read is in flight -> DO_VALID=0, EMPTY=1, COUNT=0, OVF=UNF=0 on the next cycle.
- With EBR_FIFO_PARITY_EN: force-flip bit 4 of a stored word through a hierarchical reference -> PERR=1 coincident with that word's DO_VALID; other words give PERR=0.

Source files
------------

// File: rtl/ebr_fifo_pkg.sv
// Shared types, limits and sizing helpers for the EBR-style synchronous FIFO.
package ebr_fifo_pkg;

  typedef enum logic {
    REG_NONE = 1'b0,
    REG_OUT  = 1'b1
  } regmode_e;

  localparam int MAX_WIDTH = 36;
  localparam int MAX_DEPTH = 16384;

  function automatic int par_lanes(input int width);
    return (width + 8) / 9;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ebr_sdp_ram.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module ebr_sdp_ram #(
  parameter int RAM_W = 18,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [RAM_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [RAM_W-1:0] rdata_o
);

  logic [RAM_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // The read register clears on reset so the FIFO output starts at zero.
  always_ff @(posedge CLK) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ebr_fifo_core.sv
// Parametrised synchronous FIFO in the style of the EBR FIFO16K mode.
// Define EBR_FIFO_PARITY_EN to store per-9-bit-lane even parity and add the PERR output.
module ebr_fifo_core
  import ebr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 18,
  parameter int DEPTH         = 1024,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int REGMODE       = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WE,
  input  logic [DATA_WIDTH-1:0]     DI,
  input  logic                      RE,
  output logic [DATA_WIDTH-1:0]     DO,
  output logic                      DO_VALID,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      AFULL,
  output logic                      AEMPTY,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      OVF,
  output logic                      UNF
`ifdef EBR_FIFO_PARITY_EN
  ,
  output logic                      PERR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef EBR_FIFO_PARITY_EN
  localparam int PW    = par_lanes(DATA_WIDTH);
  localparam int RAM_W = DATA_WIDTH + PW;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Returns {full, empty, afull, aempty} for a given occupancy.
  function automatic logic [3:0] flags_of(input logic [CW-1:0] c);
    flags_of = {c == DEPTH_C, c == '0,
                int'(c) >= AFULL_THRESH, int'(c) <= AEMPTY_THRESH};
  endfunction

`ifdef EBR_FIFO_PARITY_EN
  function automatic logic [PW-1:0] gen_par(input logic [DATA_WIDTH-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) p[i/9] = p[i/9] ^ d[i];
    return p;
  endfunction
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, unf_q;
  logic          vld_p0;
  logic          wr_ok, rd_ok;
  logic [RAM_W-1:0]      ram_wdata, ram_rdata;
  logic [DATA_WIDTH-1:0] rd_data;

  // Accept decisions use registered flags only: no same-cycle space or fall-through.
  assign wr_ok = WE & ~full_q;
  assign rd_ok = RE & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_A;
    if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_A;
    if (wr_ok && !rd_ok)      count_d = count_q + ONE_C;
    else if (rd_ok && !wr_ok) count_d = count_q - ONE_C;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      {full_q, empty_q, afull_q, aempty_q} <= flags_of('0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      {full_q, empty_q, afull_q, aempty_q} <= flags_of(count_d);
      ovf_q    <= ovf_q | (WE & full_q);
      unf_q    <= unf_q | (RE & empty_q);
      vld_p0   <= rd_ok;
    end
  end

`ifdef EBR_FIFO_PARITY_EN
  assign ram_wdata = {gen_par(DI), DI};
`else
  assign ram_wdata = DI;
`endif

  ebr_sdp_ram #(
    .RAM_W (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK     (CLK),
    .rst_i   (RST),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign rd_data = ram_rdata[DATA_WIDTH-1:0];

`ifdef EBR_FIFO_PARITY_EN
  logic mism_p0;
  assign mism_p0 = vld_p0 & (|(gen_par(rd_data) ^ ram_rdata[RAM_W-1:DATA_WIDTH]));
`endif

  // Output stage: either straight from the RAM read register or one more register.
  if (REGMODE == int'(REG_OUT)) begin : g_reg
    logic [DATA_WIDTH-1:0] do_p1;
    logic                  vld_p1;
`ifdef EBR_FIFO_PARITY_EN
    logic                  perr_p1;
`endif
    always_ff @(posedge CLK) begin
      if (RST) begin
        do_p1   <= '0;
        vld_p1  <= 1'b0;
`ifdef EBR_FIFO_PARITY_EN
        perr_p1 <= 1'b0;
`endif
      end else begin
        vld_p1  <= vld_p0;
        if (vld_p0) do_p1 <= rd_data;
`ifdef EBR_FIFO_PARITY_EN
        perr_p1 <= mism_p0;
`endif
      end
    end
    assign DO       = do_p1;
    assign DO_VALID = vld_p1;
`ifdef EBR_FIFO_PARITY_EN
    assign PERR     = perr_p1;
`endif
  end else begin : g_noreg
    assign DO       = rd_data;
    assign DO_VALID = vld_p0;
`ifdef EBR_FIFO_PARITY_EN
    assign PERR     = mism_p0;
`endif
  end

  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign AFULL  = afull_q;
  assign AEMPTY = aempty_q;
  assign COUNT  = count_q;
  assign OVF    = ovf_q;
  assign UNF    = unf_q;

endmodule

// File: tb/tb_ebr_fifo_core.sv
// Bench for ebr_fifo_core: REGMODE=0 and REGMODE=1 instances share one stimulus and a queue model.
module tb_ebr_fifo_core;

  localparam int DW = 18;
  localparam int DP = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst, we, re;
  logic [DW-1:0] di;

  logic [DW-1:0] do0, do1;
  logic          dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic          ovf0, ovf1, unf0, unf1;
  logic [4:0]    cnt0, cnt1;
`ifdef EBR_FIFO_PARITY_EN
  logic          perr0, perr1;
`endif

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  always #5 clk = ~clk;

  ebr_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .REGMODE(0)) d0 (
    .CLK(clk), .RST(rst), .WE(we), .DI(di), .RE(re), .DO(do0), .DO_VALID(dv0),
    .FULL(full0), .EMPTY(empty0), .AFULL(af0), .AEMPTY(ae0), .COUNT(cnt0),
    .OVF(ovf0), .UNF(unf0)
`ifdef EBR_FIFO_PARITY_EN
    , .PERR(perr0)
`endif
  );

  ebr_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .REGMODE(1)) d1 (
    .CLK(clk), .RST(rst), .WE(we), .DI(di), .RE(re), .DO(do1), .DO_VALID(dv1),
    .FULL(full1), .EMPTY(empty1), .AFULL(af1), .AEMPTY(ae1), .COUNT(cnt1),
    .OVF(ovf1), .UNF(unf1)
`ifdef EBR_FIFO_PARITY_EN
    , .PERR(perr1)
`endif
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: a queue of stored words plus the read-latency view of each instance.
  typedef struct { logic [DW-1:0] data; bit bad; } ent_t;
  ent_t          q[$];
  bit            m_ovf, m_unf;
  bit            m_v0, m_v1, m_p0, m_p1, s_v, s_p;
  logic [DW-1:0] m_do0, m_do1, s_d;

  always @(posedge clk) begin
    bit   rd, wr;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0;
      m_v0 = 0; m_v1 = 0; m_p0 = 0; m_p1 = 0; s_v = 0; s_p = 0;
      m_do0 = '0; m_do1 = '0; s_d = '0;
    end else begin
      m_v1 = s_v;
      m_p1 = s_v && s_p;
      if (s_v) m_do1 = s_d;
      rd = re && q.size() != 0;
      wr = we && q.size() != DP;
      if (we && !wr) m_ovf = 1;
      if (re && !rd) m_unf = 1;
      m_v0 = rd;
      s_v  = rd;
      m_p0 = 0;
      if (rd) begin
        e = q.pop_front();
        m_do0 = e.data; m_p0 = e.bad;
        s_d = e.data;   s_p = e.bad;
      end
      if (wr) q.push_back('{data: di, bad: 1'b0});
    end
  end

  always @(negedge clk) begin
    int n;
    if (en) begin
      n = q.size();
      chk("count0", cnt0, n);        chk("count1", cnt1, n);
      chk("full0", full0, n == DP);  chk("full1", full1, n == DP);
      chk("empty0", empty0, n == 0); chk("empty1", empty1, n == 0);
      chk("afull0", af0, n >= AF);   chk("afull1", af1, n >= AF);
      chk("aempty0", ae0, n <= AE);  chk("aempty1", ae1, n <= AE);
      chk("ovf0", ovf0, m_ovf);      chk("ovf1", ovf1, m_ovf);
      chk("unf0", unf0, m_unf);      chk("unf1", unf1, m_unf);
      chk("dv0", dv0, m_v0);         chk("dv1", dv1, m_v1);
      chk("do0", do0, m_do0);        chk("do1", do1, m_do1);
`ifdef EBR_FIFO_PARITY_EN
      chk("perr0", perr0, m_p0);     chk("perr1", perr1, m_p1);
`endif
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    we = w; di = d; re = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; di = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    en = 1'b1;
    chk("rst_empty", empty0, 1);  chk("rst_count", cnt1, 0);
    chk("rst_aempty", ae0, 1);    chk("rst_full", full1, 0);
    chk("rst_afull", af0, 0);     chk("rst_dv1", dv1, 0);
    chk("rst_do0", do0, 0);
    rst = 1'b0;

    // Fill to full.
    for (int i = 1; i <= DP; i++) begin
      cyc(1, DW'(i), 0);
      chk("fill_count", cnt0, i);
      chk("fill_afull", af0, i >= AF);
    end
    chk("fill_full", full0, 1);
    cyc(0, 0, 0);

    // Full boundary: read wins, write rejected.
    cyc(1, 18'h3FFFF, 1);
    chk("bnd_ovf", ovf0, 1);
    chk("bnd_count", cnt0, 15);
    chk("bnd_do0", do0, 18'h00001);
    chk("bnd_dv1_early", dv1, 0);
    cyc(0, 0, 0);
    chk("bnd_dv1_late", dv1, 1);
    chk("bnd_do1", do1, 18'h00001);

    // Drain the rest in order.
    for (int i = 2; i <= DP; i++) begin
      cyc(0, 0, 1);
      chk("drain_do0", do0, DW'(i));
    end
    chk("drain_empty", empty0, 1);
    cyc(0, 0, 0);
    chk("drain_do1", do1, 18'h00010);
    cyc(0, 0, 0);

    // Empty boundary: write accepted, read rejected.
    cyc(1, 18'h00ABC, 1);
    chk("eb_unf", unf0, 1);
    chk("eb_count", cnt0, 1);
    cyc(0, 0, 1);
    chk("eb_do0", do0, 18'h00ABC);
    cyc(0, 0, 0);
    chk("eb_do1", do1, 18'h00ABC);

    // Wrap: alternating pairs, then simultaneous write/read with a small backlog.
    for (int k = 0; k < 20; k++) begin
      cyc(1, DW'(k * 37 + 5), 0);
      cyc(0, 0, 1);
    end
    for (int k = 0; k < 3; k++) cyc(1, DW'(18'h20000 + k), 0);
    for (int k = 0; k < 20; k++) cyc(1, DW'(k * 1111 + 7), 1);

    // Reset with a REGMODE=1 read in flight.
    cyc(0, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("mrst_dv1", dv1, 0);     chk("mrst_dv0", dv0, 0);
    chk("mrst_empty", empty1, 1); chk("mrst_count", cnt1, 0);
    chk("mrst_ovf", ovf1, 0);    chk("mrst_unf", unf1, 0);
    rst = 1'b0;
    cyc(0, 0, 0);

`ifdef EBR_FIFO_PARITY_EN
    // Corrupt bit 4 of the second stored word (address 1 after reset).
    cyc(1, 18'h00101, 0);
    cyc(1, 18'h00202, 0);
    cyc(1, 18'h00303, 0);
    d0.u_ram.mem[1][4] = ~d0.u_ram.mem[1][4];
    d1.u_ram.mem[1][4] = ~d1.u_ram.mem[1][4];
    q[1].data = q[1].data ^ 18'h00010;
    q[1].bad  = 1'b1;
    cyc(0, 0, 1);
    chk("par_first", perr0, 0);
    cyc(0, 0, 1);
    chk("par_bad", perr0, 1);
    cyc(0, 0, 1);
    chk("par_third", perr0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
`endif

    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
